// File: rtl/ternary_conv_pkg.sv
// ternary_conv_pkg: kernel weight encodings and width helpers shared by the ternary conv MAC.
package ternary_conv_pkg;
  localparam logic [1:0] KW_ZERO = 2'b00;
  localparam logic [1:0] KW_POS  = 2'b01;
  localparam logic [1:0] KW_RSVD = 2'b10;
  localparam logic [1:0] KW_NEG  = 2'b11;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  function automatic int sum_w(input int data_w, input int n);
    return data_w + 1 + clog2(n);
  endfunction
endpackage

// File: rtl/pipelined_adder_tree.sv
// pipelined_adder_tree: registered binary adder tree, zero-padded to a power of two, growing one bit per level.
module pipelined_adder_tree
  import ternary_conv_pkg::*;
#(
  parameter int IN_W = 10,
  parameter int N = 25,
  localparam int D = clog2(N)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  input  logic                   in_last,
  input  logic [N*IN_W-1:0]      data,
  output logic signed [IN_W+D-1:0] sum,
  output logic                   out_valid,
  output logic                   out_last,
  output logic                   busy
);
  localparam int P = 1 << D;
  logic [P*IN_W-1:0] pad;
  logic [D:0] vbits;
  always_comb begin
    pad = '0;
    pad[N*IN_W-1:0] = data;
  end
  for (genvar l = 0; l <= D; l++) begin : g_lvl
    localparam int W = IN_W + l;
    localparam int M = P >> l;
    logic [M*W-1:0] v;
    logic vld, lst;
    if (l == 0) begin : g_in
      assign v = pad;
      assign vld = in_valid;
      assign lst = in_last;
    end else begin : g_add
      // each pair is sign-extended one bit before adding, so no carry is ever lost
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          v <= '0;
          vld <= 1'b0;
          lst <= 1'b0;
        end else begin
          for (int j = 0; j < M; j++)
            v[j*W +: W] <= W'($signed(g_lvl[l-1].v[2*j*(W-1) +: W-1]))
                         + W'($signed(g_lvl[l-1].v[(2*j+1)*(W-1) +: W-1]));
          vld <= g_lvl[l-1].vld;
          lst <= g_lvl[l-1].lst;
        end
      end
    end
    assign vbits[l] = vld;
  end
  assign sum = g_lvl[D].v;
  assign out_valid = g_lvl[D].vld;
  assign out_last = g_lvl[D].lst;
  assign busy = |vbits;
endmodule

// File: rtl/ternary_conv_mac.sv
// ternary_conv_mac: K*K ternary-weight dot product, pipelined tree sum, per-pixel channel accumulation with saturation.
module ternary_conv_mac
  import ternary_conv_pkg::*;
#(
  parameter int DATA_W = 9,
  parameter int K = 5,
  parameter int OUT_W = 16,
  parameter int ACC_W = 24
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  input  logic                   in_last,
  input  logic [K*K*DATA_W-1:0]  feature_in,
  input  logic [K*K*2-1:0]       kernel,
  output logic                   out_valid,
  output logic [OUT_W-1:0]       out_data,
  output logic                   out_sat,
  output logic                   busy
);
  localparam int N = K * K;
  localparam int PW = DATA_W + 1;
  localparam int SUM_W = sum_w(DATA_W, N);
  localparam logic signed [ACC_W-1:0] MAX_V = ACC_W'(2 ** (OUT_W - 1) - 1);
  localparam logic signed [ACC_W-1:0] MIN_V = ~MAX_V;

  logic [N*PW-1:0] prod_d, prod;
  logic s0_valid, s0_last;
  logic signed [SUM_W-1:0] sum;
  logic t_valid, t_last, t_busy;
  logic signed [ACC_W-1:0] acc, acc_next;
  logic clear, hi, lo;

  // one extra bit lets -(-2^(DATA_W-1)) be represented exactly
  always_comb begin
    prod_d = '0;
    for (int i = 0; i < N; i++)
      prod_d[i*PW +: PW] = kernel[i*2 +: 2] == KW_POS ? PW'($signed(feature_in[i*DATA_W +: DATA_W]))
                         : kernel[i*2 +: 2] == KW_NEG ? -PW'($signed(feature_in[i*DATA_W +: DATA_W]))
                         : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod <= '0;
      s0_valid <= 1'b0;
      s0_last <= 1'b0;
    end else begin
      prod <= prod_d;
      s0_valid <= in_valid;
      s0_last <= in_last;
    end
  end

  pipelined_adder_tree #(.IN_W(PW), .N(N)) u_tree (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(s0_valid),
    .in_last(s0_last),
    .data(prod),
    .sum(sum),
    .out_valid(t_valid),
    .out_last(t_last),
    .busy(t_busy)
  );

  always_comb begin
    acc_next = (clear ? '0 : acc) + ACC_W'(sum);
    hi = acc_next > MAX_V;
    lo = acc_next < MIN_V;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
      clear <= 1'b1;
      out_valid <= 1'b0;
      out_data <= '0;
      out_sat <= 1'b0;
    end else begin
      out_valid <= t_valid & t_last;
      if (t_valid) begin
        acc <= acc_next;
        clear <= t_last;
      end
      if (t_valid & t_last) begin
        out_data <= hi ? OUT_W'(MAX_V) : lo ? OUT_W'(MIN_V) : acc_next[OUT_W-1:0];
        out_sat <= hi | lo;
      end
    end
  end

  assign busy = t_busy | ~clear;
endmodule
